// File: rtl/umax_serial_reduce.sv
// Packet-wise unsigned maximum with first-occurrence index and word count.
// Candidates are compared against the running best one digit per cycle, MSB first.
module umax_serial_reduce #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_count
);

  localparam int unsigned ND    = WIDTH / DIGIT;
  localparam int unsigned DIG_W = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_FIRST,
    S_WAIT,
    S_CMP,
    S_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   best_q, best_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   cand_q, cand_d;
  logic               last_q, last_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_max_q, out_max_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [IDX_W-1:0]   out_count_q, out_count_d;

  logic               in_xfer;
  logic               out_xfer;
  logic [DIG_W-1:0]   sel;
  logic [DIGIT-1:0]   cand_dig;
  logic [DIGIT-1:0]   best_dig;
  logic               win;
  logic               lose;
  logic               resolve;

  // Acceptance depends on state (and reset) only, never on in_valid.
  assign in_ready  = !rst && ((state_q == S_FIRST) || (state_q == S_WAIT));
  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_idx   = out_idx_q;
  assign out_count = out_count_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  // Digit currently under comparison, counted down from the most significant.
  always_comb begin
    sel      = DIG_W'(ND - 1) - dig_q;
    cand_dig = '0;
    best_dig = '0;
    for (int unsigned i = 0; i < ND; i++) begin
      if (sel == DIG_W'(i)) begin
        cand_dig = cand_q[i*DIGIT +: DIGIT];
        best_dig = best_q[i*DIGIT +: DIGIT];
      end
    end
    win     = cand_dig > best_dig;
    lose    = cand_dig < best_dig;
    resolve = win || lose || (dig_q == DIG_W'(ND - 1));
  end

  always_comb begin
    state_d     = state_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    last_d      = last_q;
    dig_d       = dig_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    out_count_d = out_count_q;

    case (state_q)
      S_FIRST: begin
        if (in_xfer) begin
          best_d     = in_data;
          best_idx_d = '0;
          cnt_d      = IDX_W'(1);
          state_d    = in_last ? S_OUT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (in_xfer) begin
          cand_d  = in_data;
          last_d  = in_last;
          dig_d   = '0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (resolve) begin
          // A full-width tie keeps the earlier word.
          if (win) begin
            best_d     = cand_q;
            best_idx_d = cnt_q;
          end
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + IDX_W'(1);
          end
          state_d = last_q ? S_OUT : S_WAIT;
        end else begin
          dig_d = dig_q + DIG_W'(1);
        end
      end
      S_OUT: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          state_d     = S_FIRST;
        end
      end
      default: state_d = S_FIRST;
    endcase

    // Result fields are captured once on entry and held until accepted.
    if ((state_d == S_OUT) && (state_q != S_OUT)) begin
      out_valid_d = 1'b1;
      out_max_d   = best_d;
      out_idx_d   = best_idx_d;
      out_count_d = cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FIRST;
      best_q      <= '0;
      best_idx_q  <= '0;
      cnt_q       <= '0;
      cand_q      <= '0;
      last_q      <= 1'b0;
      dig_q       <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      last_q      <= last_d;
      dig_q       <= dig_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_umax_serial_reduce.sv
// Bench for umax_serial_reduce: an IDX_W=8 and an IDX_W=2 instance share the input stream.
module tb_umax_serial_reduce;

  localparam int BUDGET = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;
  logic        in_ready, in_ready_s;
  logic        out_valid, out_valid_s;
  logic [31:0] out_max, out_max_s;
  logic [7:0]  out_idx, out_count;
  logic [1:0]  out_idx_s, out_count_s;

  typedef struct packed {
    logic [31:0] mx;
    logic [7:0]  idx;
    logic [7:0]  cnt;
    logic [1:0]  idx_s;
    logic [1:0]  cnt_s;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pkt[$];
  int          gaps[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  umax_serial_reduce #(.WIDTH(32), .DIGIT(4), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx),
    .out_count(out_count)
  );

  umax_serial_reduce #(.WIDTH(32), .DIGIT(4), .IDX_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_max(out_max_s), .out_idx(out_idx_s),
    .out_count(out_count_s)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Drives the first nsend words of pkt; optionally queues the expected result.
  task automatic send_pkt(input bit push, input int nsend);
    exp_t e;
    e.mx = pkt[0]; e.idx = 0; e.idx_s = 0;
    for (int i = 1; i < pkt.size(); i++) begin
      if (pkt[i] > e.mx) begin
        e.mx    = pkt[i];
        e.idx   = 8'(imin(i, 255));
        e.idx_s = 2'(imin(i, 3));
      end
    end
    e.cnt   = 8'(imin(pkt.size(), 255));
    e.cnt_s = 2'(imin(pkt.size(), 3));
    if (push) sb.push_back(e);
    gaps.delete();
    for (int i = 0; i < nsend; i++) begin
      int g = 0;
      while (!in_ready && g < BUDGET) begin
        @(negedge clk);
        g++;
      end
      if (!in_ready) begin
        n_cmp++; n_fail++;
        $display("FAIL send_ready: in_ready=%0b after %0d cycles, required 1", in_ready, g);
        return;
      end
      gaps.push_back(g);
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == pkt.size() - 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 'x;
      in_last  = 'x;
    end
  endtask

  // Waits for a result, checks it against the scoreboard, holds off for `hold` cycles, accepts it.
  task automatic collect(input int hold, input int exp_wait);
    exp_t e;
    int   w = 0;
    while (!out_valid && w < BUDGET) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL out_timeout: out_valid=%0b, required 1", out_valid);
      return;
    end
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: unexpected result max=%0h, required no result", out_max);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (out_max !== e.mx) begin
      n_fail++; $display("FAIL out_max: got %0h required %0h", out_max, e.mx);
    end
    n_cmp++;
    if (out_idx !== e.idx) begin
      n_fail++; $display("FAIL out_idx: got %0d required %0d", out_idx, e.idx);
    end
    n_cmp++;
    if (out_count !== e.cnt) begin
      n_fail++; $display("FAIL out_count: got %0d required %0d", out_count, e.cnt);
    end
    n_cmp++;
    if ({out_valid_s, out_max_s, out_idx_s, out_count_s} !== {1'b1, e.mx, e.idx_s, e.cnt_s}) begin
      n_fail++;
      $display("FAIL sat_result: got v=%0b max=%0h idx=%0d cnt=%0d required v=1 max=%0h idx=%0d cnt=%0d",
               out_valid_s, out_max_s, out_idx_s, out_count_s, e.mx, e.idx_s, e.cnt_s);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_in_out: in_ready=%0b required 0", in_ready);
    end
    if (exp_wait >= 0) begin
      n_cmp++;
      if (w !== exp_wait) begin
        n_fail++; $display("FAIL out_latency: waited %0d cycles required %0d", w, exp_wait);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, out_max, out_idx, out_count} !== {1'b1, 1'b0, e.mx, e.idx, e.cnt}) begin
        n_fail++;
        $display("FAIL hold_stable: cycle %0d v=%0b rdy=%0b max=%0h idx=%0d cnt=%0d required v=1 rdy=0 max=%0h idx=%0d cnt=%0d",
                 h, out_valid, in_ready, out_max, out_idx, out_count, e.mx, e.idx, e.cnt);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_xfer: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic check_gap(input int i, input int exp);
    n_cmp++;
    if (gaps.size() <= i || gaps[i] !== exp) begin
      n_fail++;
      $display("FAIL ready_gap%0d: got %0d required %0d", i, (gaps.size() > i) ? gaps[i] : -1, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_max, out_idx, out_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%0b v=%0b max=%0h idx=%0d cnt=%0d required all 0",
               in_ready, out_valid, out_max, out_idx, out_count);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    pkt = '{32'd5, 32'hFFFF_FFFF, 32'd7};
    send_pkt(1'b1, 3);
    check_gap(1, 0);
    check_gap(2, 1);
    collect(0, 1);
  endtask

  task automatic test_single();
    pkt = '{32'h1234_5678};
    send_pkt(1'b1, 1);
    collect(2, 0);
  endtask

  task automatic test_tie();
    pkt = '{32'h0000_00A0, 32'h0000_00A0};
    send_pkt(1'b1, 2);
    collect(0, 8);
  endtask

  task automatic test_early_term();
    pkt = '{32'h1000_0000, 32'h8000_0000};
    send_pkt(1'b1, 2);
    collect(0, 1);
    pkt = '{32'h1234_5670, 32'h1234_5671};
    send_pkt(1'b1, 2);
    collect(0, 8);
  endtask

  task automatic test_backpressure();
    pkt = '{32'h0000_0042, 32'h0000_0041, 32'h0F00_0000};
    send_pkt(1'b1, 3);
    check_gap(2, 8);
    collect(5, 2);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    pkt = '{32'h11, 32'h12, 32'h13};
    send_pkt(1'b0, 2);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_cmp: in_ready=%0b required 0", in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_max, out_idx, out_count} !== {1'b1, 1'b0, 32'h0, 8'h0, 8'h0}) begin
      n_fail++;
      $display("FAIL mid_reset_state: rdy=%0b v=%0b max=%0h idx=%0d cnt=%0d required 1/0/0/0/0",
               in_ready, out_valid, out_max, out_idx, out_count);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL mid_no_result: out_valid high %0d cycles required 0", seen);
    end
    pkt = '{32'd3, 32'd9};
    send_pkt(1'b1, 2);
    collect(0, 8);
  endtask

  task automatic test_saturation();
    pkt = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    send_pkt(1'b1, 5);
    collect(0, 8);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 6; p++) begin
      int n = $urandom_range(1, 6);
      pkt.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: pkt.push_back(32'h0);
          1: pkt.push_back(32'h8000_0001);
          2: pkt.push_back(32'hFFFF_FFFF);
          default: pkt.push_back($urandom());
        endcase
      end
      send_pkt(1'b1, n);
      collect($urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_tie();
    test_early_term();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: %0d results outstanding required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
